// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: FSM encoding, load op codes and
// tag constants used by the load queue and the CDB side.
package load_unit_pkg;

  // Load unit FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lu_state_e;

  // Load op codes as presented on opIn
  localparam logic OP_LW = 1'b0;
  localparam logic OP_LH = 1'b1;

  // Issue tag width and the reserved "no instruction" tag
  localparam int TAG_W = 5;
  localparam logic [TAG_W-1:0] TAG_NULL = '0;

  // Tags of the three load-queue entries
  localparam logic [TAG_W-1:0] q0 = 5'd1;
  localparam logic [TAG_W-1:0] q1 = 5'd2;
  localparam logic [TAG_W-1:0] q2 = 5'd3;

  // Build the broadcast value from the raw memory word: a full word, or the
  // halfword picked by address bit 1, sign-extended.
  function automatic logic [31:0] format_load(input logic op,
                                              input logic half_sel,
                                              input logic [31:0] word);
    logic [15:0] half;
    half = half_sel ? word[31:16] : word[15:0];
    if (op == OP_LH) begin
      return {{16{half[15]}}, half};
    end
    return word;
  endfunction

endpackage

// File: rtl/load_mem.sv
// Word-addressed data memory for the load unit: one synchronous write port
// (preload) and one combinational read port (load path). Contents are not
// reset.
module load_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Preload write lands on the clock edge
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational, so a write on the same edge as the result capture
  // is not yet visible to it
  assign rdata = mem[raddr];

endmodule

// File: rtl/load_unit.sv
// Load functional unit: accepts one load from the queue head, reads the local
// memory after a fixed latency, then holds the result on the CDB request until
// the arbiter grants it. A grant with a waiting op accepts it on the same edge.
module load_unit
  import load_unit_pkg::*;
#(
  parameter  int LATENCY = 3,
  parameter  int DEPTH   = 64,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             require,
  input  logic             opIn,
  input  logic [31:0]      dataIn,
  input  logic [TAG_W-1:0] labelIn,
  output logic             requireAC,
  output logic             bcReq,
  input  logic             bcGrant,
  output logic             BCEN,
  output logic [TAG_W-1:0] BClabel,
  output logic [31:0]      BCdata,
  input  logic             dbgWEN,
  input  logic [AW-1:0]    dbgAddr,
  input  logic [31:0]      dbgData
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  lu_state_e        state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic             op_reg;
  logic [AW-1:0]    idx_reg;
  logic             half_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [TAG_W-1:0] label_reg;
  logic [31:0]      data_reg;

  logic             accept;
  logic             finish;
  logic [31:0]      mem_word;

  // Byte-within-halfword bit and the bits above the memory window do not
  // take part in the access
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dataIn[31:AW+2], dataIn[0]};

  assign accept = require && requireAC;
  assign finish = (state_reg == BUSY) && (cnt_reg == 4'd0);

  load_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .wen   (dbgWEN),
    .waddr (dbgAddr),
    .wdata (dbgData),
    .raddr (idx_reg),
    .rdata (mem_word)
  );

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == 4'd0) state_next = DONE;
      end
      DONE: begin
        if (bcGrant) state_next = require ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: ready and CDB handshake, all combinational on state/grant
  always_comb begin
    requireAC = 1'b0;
    bcReq     = 1'b0;
    BCEN      = 1'b0;
    case (state_reg)
      IDLE: requireAC = 1'b1;
      DONE: begin
        requireAC = bcGrant;
        bcReq     = 1'b1;
        BCEN      = bcGrant;
      end
      default: ;
    endcase
  end

  // Capture the accepted op and run the latency counter
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_reg  <= 4'd0;
      op_reg   <= OP_LW;
      idx_reg  <= '0;
      half_reg <= 1'b0;
      tag_reg  <= TAG_NULL;
    end else if (accept) begin
      cnt_reg  <= CNT_LOAD;
      op_reg   <= opIn;
      idx_reg  <= dataIn[AW+1:2];
      half_reg <= dataIn[1];
      tag_reg  <= labelIn;
    end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Register the formatted result at the end of the access; held until the
  // next load completes
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      label_reg <= TAG_NULL;
      data_reg  <= 32'd0;
    end else if (finish) begin
      label_reg <= tag_reg;
      data_reg  <= format_load(op_reg, half_reg, mem_word);
    end
  end

  assign BClabel = label_reg;
  assign BCdata  = data_reg;

endmodule

// File: tb/tb_load_unit.sv
// Directed testbench for load_unit with LATENCY = 3, DEPTH = 64.
module tb_load_unit;

  localparam int LAT = 3;
  localparam int DEP = 64;
  localparam int AWT = 6;

  logic             clk = 1'b0;
  logic             nRST = 1'b0;
  logic             require = 1'b0;
  logic             opIn = 1'b0;
  logic [31:0]      dataIn = '0;
  logic [4:0]       labelIn = '0;
  logic             requireAC;
  logic             bcReq;
  logic             bcGrant = 1'b0;
  logic             BCEN;
  logic [4:0]       BClabel;
  logic [31:0]      BCdata;
  logic             dbgWEN = 1'b0;
  logic [AWT-1:0]   dbgAddr = '0;
  logic [31:0]      dbgData = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_unit #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .require   (require),
    .opIn      (opIn),
    .dataIn    (dataIn),
    .labelIn   (labelIn),
    .requireAC (requireAC),
    .bcReq     (bcReq),
    .bcGrant   (bcGrant),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .dbgWEN    (dbgWEN),
    .dbgAddr   (dbgAddr),
    .dbgData   (dbgData)
  );

  // Preload one word; entered and left #1 after a rising edge
  task automatic preload(input logic [AWT-1:0] a, input logic [31:0] d);
    dbgWEN = 1'b1; dbgAddr = a; dbgData = d;
    @(posedge clk); #1;
    dbgWEN = 1'b0;
  endtask

  // Present one op, let it be accepted, then count cycles until bcReq
  task automatic run_load(input logic op, input logic [31:0] addr,
                          input logic [4:0] tag, output int cyc);
    opIn = op; dataIn = addr; labelIn = tag; require = 1'b1;
    @(posedge clk); #1;
    require = 1'b0;
    cyc = 0;
    while (!bcReq && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One cycle with grant high to release a DONE result
  task automatic release_grant();
    bcGrant = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    if ({requireAC, bcReq, BCEN} !== 3'b100) begin
      failures++; $display("FAIL reset_ctrl got=%b want=100", {requireAC, bcReq, BCEN});
    end
    checks++;
    if (BClabel !== 5'd0 || BCdata !== 32'd0) begin
      failures++; $display("FAIL reset_data got=%0d/%h want=0/00000000", BClabel, BCdata);
    end
    checks++;
    nRST = 1'b1;
    @(posedge clk); #1;
    $display("reset: requireAC=%b bcReq=%b BCEN=%b", requireAC, bcReq, BCEN);
  endtask

  task automatic test_lw();
    int cyc;
    preload(6'd5, 32'h1234_5678);
    bcGrant = 1'b1;
    opIn = 1'b0; dataIn = 32'd20; labelIn = 5'd9; require = 1'b1;
    @(posedge clk); #1;
    require = 1'b0;
    if (requireAC !== 1'b0 || bcReq !== 1'b0) begin
      failures++; $display("FAIL lw_busy requireAC=%b bcReq=%b want=0 0", requireAC, bcReq);
    end
    checks++;
    cyc = 0;
    while (!bcReq && cyc < 40) begin @(posedge clk); #1; cyc++; end
    if (cyc !== LAT) begin
      failures++; $display("FAIL lw_latency got=%0d want=%0d", cyc, LAT);
    end
    checks++;
    if (BCEN !== 1'b1 || BClabel !== 5'd9 || BCdata !== 32'h1234_5678) begin
      failures++; $display("FAIL lw_bcast got=%b/%0d/%h want=1/9/12345678", BCEN, BClabel, BCdata);
    end
    checks++;
    @(posedge clk); #1;
    if ({requireAC, bcReq, BCEN} !== 3'b100) begin
      failures++; $display("FAIL lw_pulse got=%b want=100", {requireAC, bcReq, BCEN});
    end
    checks++;
    $display("lw: tag=%0d data=%h latency=%0d", BClabel, BCdata, cyc);
  endtask

  task automatic test_lh();
    int cyc;
    preload(6'd2, 32'h8001_7FFF);
    bcGrant = 1'b1;
    run_load(1'b1, 32'd8, 5'd3, cyc);
    if (BCdata !== 32'h0000_7FFF || BClabel !== 5'd3 || cyc !== LAT) begin
      failures++; $display("FAIL lh_low got=%h/%0d/%0d want=00007fff/3/%0d", BCdata, BClabel, cyc, LAT);
    end
    checks++;
    $display("lh addr=8: data=%h", BCdata);
    release_grant();
    // Tag 0 passes through unfiltered; addr bit 0 is ignored
    run_load(1'b1, 32'd11, 5'd0, cyc);
    if (BCdata !== 32'hFFFF_8001 || BClabel !== 5'd0 || BCEN !== 1'b1) begin
      failures++; $display("FAIL lh_high got=%h/%0d/%b want=ffff8001/0/1", BCdata, BClabel, BCEN);
    end
    checks++;
    $display("lh addr=11: data=%h", BCdata);
    release_grant();
  endtask

  task automatic test_stall();
    int cyc;
    bcGrant = 1'b0;
    run_load(1'b0, 32'd20, 5'd7, cyc);
    for (int i = 0; i < 4; i++) begin
      if (bcReq !== 1'b1 || BCEN !== 1'b0 || requireAC !== 1'b0 ||
          BClabel !== 5'd7 || BCdata !== 32'h1234_5678) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%b%b%b/%0d/%h want=100/7/12345678",
                 i, bcReq, BCEN, requireAC, BClabel, BCdata);
      end
      checks++;
      @(posedge clk); #1;
    end
    bcGrant = 1'b1; #1;
    if (BCEN !== 1'b1 || BClabel !== 5'd7) begin
      failures++; $display("FAIL stall_grant got=%b/%0d want=1/7", BCEN, BClabel);
    end
    checks++;
    @(posedge clk); #1;
    bcGrant = 1'b0;
    if (BCEN !== 1'b0 || bcReq !== 1'b0) begin
      failures++; $display("FAIL stall_once got=%b%b want=00", BCEN, bcReq);
    end
    checks++;
    $display("stall: released after 4 wait cycles, tag=%0d", BClabel);
  endtask

  task automatic test_back_to_back();
    int cyc;
    preload(6'd3, 32'hCAFE_0003);
    bcGrant = 1'b0;
    run_load(1'b0, 32'd20, 5'd10, cyc);
    opIn = 1'b0; dataIn = 32'd12; labelIn = 5'd11; require = 1'b1;
    bcGrant = 1'b1; #1;
    if (requireAC !== 1'b1 || BCEN !== 1'b1 || BClabel !== 5'd10 || BCdata !== 32'h1234_5678) begin
      failures++; $display("FAIL b2b_grant got=%b%b/%0d/%h want=11/10/12345678",
                           requireAC, BCEN, BClabel, BCdata);
    end
    checks++;
    @(posedge clk); #1;
    require = 1'b0;
    if (requireAC !== 1'b0 || bcReq !== 1'b0) begin
      failures++; $display("FAIL b2b_busy got=%b%b want=00", requireAC, bcReq);
    end
    checks++;
    cyc = 0;
    while (!bcReq && cyc < 40) begin @(posedge clk); #1; cyc++; end
    if (cyc !== LAT || BClabel !== 5'd11 || BCdata !== 32'hCAFE_0003) begin
      failures++; $display("FAIL b2b_second got=%0d/%0d/%h want=%0d/11/cafe0003",
                           cyc, BClabel, BCdata, LAT);
    end
    checks++;
    $display("b2b: second tag=%0d data=%h latency=%0d", BClabel, BCdata, cyc);
    release_grant();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit bad;
    bcGrant = 1'b1;
    opIn = 1'b0; dataIn = 32'd20; labelIn = 5'd12; require = 1'b1;
    @(posedge clk); #1;
    require = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b0; #1;
    if ({requireAC, bcReq, BCEN} !== 3'b100) begin
      failures++; $display("FAIL rstmid_now got=%b want=100", {requireAC, bcReq, BCEN});
    end
    checks++;
    @(posedge clk); #1;
    nRST = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bcReq !== 1'b0 || BCEN !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    if (bad !== 1'b0) begin
      failures++; $display("FAIL rstmid_nobcast got=1 want=0");
    end
    checks++;
    run_load(1'b0, 32'd20, 5'd13, cyc);
    if (cyc !== LAT || BClabel !== 5'd13 || BCdata !== 32'h1234_5678) begin
      failures++; $display("FAIL rstmid_next got=%0d/%0d/%h want=%0d/13/12345678",
                           cyc, BClabel, BCdata, LAT);
    end
    checks++;
    $display("reset mid-op: next load tag=%0d data=%h", BClabel, BCdata);
    release_grant();
  endtask

  task automatic test_wrap_write();
    int cyc;
    preload(6'd1, 32'h1111_1111);
    bcGrant = 1'b1;
    run_load(1'b0, 32'h0000_0104, 5'd14, cyc);
    if (BCdata !== 32'h1111_1111 || cyc !== LAT) begin
      failures++; $display("FAIL wrap got=%h/%0d want=11111111/%0d", BCdata, cyc, LAT);
    end
    checks++;
    $display("wrap addr=0x104: data=%h", BCdata);
    release_grant();
    // Write lands two edges before the capture edge: new value seen
    opIn = 1'b0; dataIn = 32'h0000_0104; labelIn = 5'd15; require = 1'b1;
    @(posedge clk); #1;
    require = 1'b0;
    dbgWEN = 1'b1; dbgAddr = 6'd1; dbgData = 32'h2222_2222;
    @(posedge clk); #1;
    dbgWEN = 1'b0;
    cyc = 1;
    while (!bcReq && cyc < 40) begin @(posedge clk); #1; cyc++; end
    if (BCdata !== 32'h2222_2222 || BClabel !== 5'd15 || cyc !== LAT) begin
      failures++; $display("FAIL write_early got=%h/%0d/%0d want=22222222/15/%0d",
                           BCdata, BClabel, cyc, LAT);
    end
    checks++;
    $display("early write: data=%h", BCdata);
    release_grant();
    // Write on the capture edge itself: old value returned
    opIn = 1'b0; dataIn = 32'h0000_0004; labelIn = 5'd16; require = 1'b1;
    @(posedge clk); #1;
    require = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dbgWEN = 1'b1; dbgAddr = 6'd1; dbgData = 32'h3333_3333;
    @(posedge clk); #1;
    dbgWEN = 1'b0;
    if (bcReq !== 1'b1 || BCdata !== 32'h2222_2222) begin
      failures++; $display("FAIL write_same got=%b/%h want=1/22222222", bcReq, BCdata);
    end
    checks++;
    $display("same-edge write: data=%h", BCdata);
    release_grant();
    run_load(1'b1, 32'h0000_0006, 5'd17, cyc);
    if (BCdata !== 32'h0000_3333) begin
      failures++; $display("FAIL write_after got=%h want=00003333", BCdata);
    end
    checks++;
    $display("after write lh: data=%h", BCdata);
    release_grant();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lh();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
